// File: rtl/cic_integrator_chain.sv
// Cascaded multi-channel CIC integrator section: STAGES accumulators per channel,
// one pipeline register per stage, modulo-2^ACC_WIDTH arithmetic, MSB-truncated output.
module cic_integrator_chain #(
  parameter int DATA_WIDTH_INP = 8,
  parameter int DATA_WIDTH_OUT = 12,
  parameter int ACC_WIDTH      = 12,
  parameter int STAGES         = 3,
  parameter int NUM_CH         = 1,
  parameter int USE_DSP        = 1,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clr,
  input  logic signed [DATA_WIDTH_INP-1:0] inp_samp_data,
  input  logic                             inp_samp_str,
  input  logic        [CH_W-1:0]           inp_samp_ch,
  output logic signed [DATA_WIDTH_OUT-1:0] out_samp_data,
  output logic                             out_samp_str,
  output logic        [CH_W-1:0]           out_samp_ch
);

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  if (ACC_WIDTH < DATA_WIDTH_INP || DATA_WIDTH_OUT > ACC_WIDTH || STAGES < 1 ||
      NUM_CH < 1 || (USE_DSP != 0 && USE_DSP != 1)) begin : g_bad_param
    $error("cic_integrator_chain: invalid parameter set");
  end

  function automatic acc_t sign_ext(input logic signed [DATA_WIDTH_INP-1:0] x);
    return acc_t'(x);
  endfunction

  // Wrap-around is the CIC property that cancels in the comb section.
  function automatic acc_t wrap_add(input acc_t a, input acc_t b);
    return a + b;
  endfunction

  function automatic logic signed [DATA_WIDTH_OUT-1:0] trunc_msb(input acc_t a);
    return DATA_WIDTH_OUT'(a >>> (ACC_WIDTH - DATA_WIDTH_OUT));
  endfunction

  localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

  logic ch_ok;

  acc_t            acc     [STAGES][NUM_CH];
  acc_t            sum_p   [STAGES];
  logic            vld_p   [STAGES];
  logic [CH_W-1:0] ch_p    [STAGES];

  acc_t            add_in  [STAGES];
  logic            add_vld [STAGES];
  logic [CH_W-1:0] add_ch  [STAGES];
  acc_t            new_sum [STAGES];

  assign ch_ok = ({1'b0, inp_samp_ch} < NUM_CH_L);

  always_comb begin
    add_in[0]  = sign_ext(inp_samp_data);
    add_vld[0] = inp_samp_str && ch_ok;
    add_ch[0]  = ch_ok ? inp_samp_ch : '0;
    for (int k = 1; k < STAGES; k++) begin
      add_in[k]  = sum_p[k-1];
      add_vld[k] = vld_p[k-1];
      add_ch[k]  = ch_p[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      new_sum[k] = wrap_add(acc[k][add_ch[k]], add_in[k]);
    end
  end

  // Stage k registers: acc[k][*] plus the sum_p/vld_p/ch_p pipeline register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        for (int c = 0; c < NUM_CH; c++) acc[k][c] <= '0;
        vld_p[k] <= 1'b0;
        sum_p[k] <= '0;
        ch_p[k]  <= '0;
      end
    end else if (clr) begin
      for (int k = 0; k < STAGES; k++) begin
        for (int c = 0; c < NUM_CH; c++) acc[k][c] <= '0;
        vld_p[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= add_vld[k];
        if (add_vld[k]) begin
          acc[k][add_ch[k]] <= new_sum[k];
          sum_p[k]          <= new_sum[k];
          ch_p[k]           <= add_ch[k];
        end
      end
    end
  end

  assign out_samp_data = trunc_msb(sum_p[STAGES-1]);
  assign out_samp_str  = vld_p[STAGES-1];
  assign out_samp_ch   = ch_p[STAGES-1];

endmodule
